// File: rtl/hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : hit_judge
// Function : Debounces the red/blue play buttons, judges presses against the
//            judge-cell note, and keeps score, grade counters and flash code.
// Revision : 1.0
// ============================================================================
module hit_judge #(
    parameter logic [17:0] DEBOUNCE_CYCLES = 18'd200000,
    parameter logic [23:0] FLASH_CYCLES    = 24'd5000000,
    parameter logic [15:0] PERFECT_PTS     = 16'd3,
    parameter logic [15:0] GOOD_PTS        = 16'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        note_R_judge,
    input  logic        note_B_judge,
    input  logic [2:0]  offset,
    input  logic        finish,
    output logic        delete,
    output logic [15:0] score,
    output logic [9:0]  perfect_cnt,
    output logic [9:0]  good_cnt,
    output logic [9:0]  bad_cnt,
    output logic [1:0]  hit_flash
);

    localparam logic [17:0] c_DB_LAST    = DEBOUNCE_CYCLES - 18'd1;
    localparam logic [23:0] c_FLASH_LAST = FLASH_CYCLES - 24'd1;
    localparam logic [9:0]  c_CNT_MAX    = 10'h3FF;

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  w_raw;
    logic [1:0]  w_press;
    logic        w_hit;
    logic        w_bad;
    logic        w_clear;
    logic        w_perfect;
    logic [15:0] w_pts;
    logic [16:0] w_sum;
    logic [15:0] w_score_sat;

    logic        r_delete;
    logic [15:0] r_score;
    logic [9:0]  r_perfect_cnt;
    logic [9:0]  r_good_cnt;
    logic [9:0]  r_bad_cnt;
    logic [1:0]  r_flash;
    logic [23:0] r_flash_cnt;

    assign w_raw = {blue_button, red_button};

    // Index 0 is red, index 1 is blue.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]  r_sync;
            logic [17:0] r_cnt;
            logic        r_acc;
            logic        r_acc_d;
            logic        r_press;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync  <= 2'b00;
                    r_cnt   <= 18'd0;
                    r_acc   <= 1'b0;
                    r_acc_d <= 1'b0;
                    r_press <= 1'b0;
                end else begin
                    r_sync  <= {r_sync[0], w_raw[gi]};
                    r_acc_d <= r_acc;
                    r_press <= r_acc & ~r_acc_d;
                    if (r_sync[1] == r_acc) begin
                        r_cnt <= 18'd0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_cnt <= 18'd0;
                        r_acc <= ~r_acc;
                    end else begin
                        r_cnt <= r_cnt + 18'd1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        w_bad       = 1'b0;
        w_clear     = 1'b0;
        if (finish) begin
            w_state_nxt = S_DONE;
        end else begin
            case (r_state)
                S_PLAY: begin
                    // A matching press wins; the other simultaneous press is dropped.
                    if ((w_press[0] && note_R_judge) || (w_press[1] && note_B_judge)) begin
                        w_hit       = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else if (|w_press) begin
                        w_bad = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!note_R_judge && !note_B_judge) begin
                        w_state_nxt = S_PLAY;
                    end
                end
                S_DONE: begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_PLAY;
                end
                default: begin
                    w_state_nxt = S_PLAY;
                end
            endcase
        end
    end

    assign w_perfect   = (offset >= 3'd2) && (offset <= 3'd4);
    assign w_pts       = w_perfect ? PERFECT_PTS : GOOD_PTS;
    assign w_sum       = {1'b0, r_score} + {1'b0, w_pts};
    assign w_score_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delete      <= 1'b0;
            r_score       <= 16'd0;
            r_perfect_cnt <= 10'd0;
            r_good_cnt    <= 10'd0;
            r_bad_cnt     <= 10'd0;
            r_flash       <= 2'd0;
            r_flash_cnt   <= 24'd0;
        end else begin
            r_delete <= w_hit;
            if (w_clear) begin
                r_score       <= 16'd0;
                r_perfect_cnt <= 10'd0;
                r_good_cnt    <= 10'd0;
                r_bad_cnt     <= 10'd0;
                r_flash       <= 2'd0;
                r_flash_cnt   <= 24'd0;
            end else if (!finish) begin
                if (w_hit) begin
                    r_score     <= w_score_sat;
                    r_flash_cnt <= c_FLASH_LAST;
                    if (w_perfect) begin
                        r_flash <= 2'd1;
                        if (r_perfect_cnt != c_CNT_MAX) r_perfect_cnt <= r_perfect_cnt + 10'd1;
                    end else begin
                        r_flash <= 2'd2;
                        if (r_good_cnt != c_CNT_MAX) r_good_cnt <= r_good_cnt + 10'd1;
                    end
                end else if (w_bad) begin
                    r_flash     <= 2'd3;
                    r_flash_cnt <= c_FLASH_LAST;
                    if (r_bad_cnt != c_CNT_MAX) r_bad_cnt <= r_bad_cnt + 10'd1;
                end else if (r_flash_cnt != 24'd0) begin
                    r_flash_cnt <= r_flash_cnt - 24'd1;
                end else begin
                    r_flash <= 2'd0;
                end
            end
        end
    end

    assign delete      = r_delete;
    assign score       = r_score;
    assign perfect_cnt = r_perfect_cnt;
    assign good_cnt    = r_good_cnt;
    assign bad_cnt     = r_bad_cnt;
    assign hit_flash   = r_flash;

endmodule
`default_nettype wire

// File: tb/tb_hit_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_judge
// Function : Directed and randomized bench for hit_judge with a cycle-level
//            behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_hit_judge;

    localparam int c_D  = 4;
    localparam int c_F  = 8;
    localparam int c_PP = 16384;
    localparam int c_GP = 1;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        red_button   = 1'b0;
    logic        blue_button  = 1'b0;
    logic        note_R_judge = 1'b0;
    logic        note_B_judge = 1'b0;
    logic [2:0]  offset       = 3'd0;
    logic        finish       = 1'b0;
    logic        delete;
    logic [15:0] score;
    logic [9:0]  perfect_cnt;
    logic [9:0]  good_cnt;
    logic [9:0]  bad_cnt;
    logic [1:0]  hit_flash;

    hit_judge #(
        .DEBOUNCE_CYCLES(18'(c_D)),
        .FLASH_CYCLES   (24'(c_F)),
        .PERFECT_PTS    (16'(c_PP)),
        .GOOD_PTS       (16'(c_GP))
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .red_button  (red_button),
        .blue_button (blue_button),
        .note_R_judge(note_R_judge),
        .note_B_judge(note_B_judge),
        .offset      (offset),
        .finish      (finish),
        .delete      (delete),
        .score       (score),
        .perfect_cnt (perfect_cnt),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt),
        .hit_flash   (hit_flash)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_del = 0;
    bit auto_clear = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: game state 0 play, 1 hold, 2 done.
    int m_state;
    int m_score, m_perf, m_good, m_bad, m_flash, m_left;
    bit m_del;
    bit m_dly[2][2];
    bit m_hist[2][$];
    bit m_acc[2];
    bit m_rose[2];
    bit m_ev[2];

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic m_reset();
        m_state = 0; m_score = 0; m_perf = 0; m_good = 0; m_bad = 0;
        m_flash = 0; m_left = 0; m_del = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_dly[b][0] = 1'b0; m_dly[b][1] = 1'b0;
            m_hist[b].delete();
            m_acc[b] = 1'b0; m_rose[b] = 1'b0; m_ev[b] = 1'b0;
        end
    endtask

    task automatic m_flash_age();
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_flash = 0;
        end
    endtask

    task automatic m_step();
        bit raw[2];
        bit ev[2];
        bit all_diff;
        bit hit_r, hit_b;
        raw[0] = red_button;
        raw[1] = blue_button;
        ev = m_ev;
        m_del = 1'b0;
        if (finish) begin
            m_state = 2;
        end else if (m_state == 2) begin
            m_score = 0; m_perf = 0; m_good = 0; m_bad = 0; m_flash = 0; m_left = 0;
            m_state = 0;
        end else if (m_state == 1) begin
            if (!note_R_judge && !note_B_judge) m_state = 0;
            m_flash_age();
        end else begin
            hit_r = ev[0] && note_R_judge;
            hit_b = ev[1] && note_B_judge;
            if (hit_r || hit_b) begin
                m_del = 1'b1;
                m_state = 1;
                m_left = c_F;
                if (offset >= 2 && offset <= 4) begin
                    m_score = sat(m_score + c_PP, 65535);
                    m_perf  = sat(m_perf + 1, 1023);
                    m_flash = 1;
                end else begin
                    m_score = sat(m_score + c_GP, 65535);
                    m_good  = sat(m_good + 1, 1023);
                    m_flash = 2;
                end
            end else if (ev[0] || ev[1]) begin
                m_bad = sat(m_bad + 1, 1023);
                m_flash = 3;
                m_left = c_F;
            end else begin
                m_flash_age();
            end
        end
        // Accepted level flips once the synchronized level has disagreed for D cycles.
        for (int b = 0; b < 2; b++) begin
            m_ev[b] = m_rose[b];
            m_rose[b] = 1'b0;
            m_hist[b].push_back(m_dly[b][1]);
            if (m_hist[b].size() > c_D) void'(m_hist[b].pop_front());
            if (m_hist[b].size() == c_D) begin
                all_diff = 1'b1;
                foreach (m_hist[b][k]) if (m_hist[b][k] == m_acc[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_acc[b] = ~m_acc[b];
                    m_rose[b] = m_acc[b];
                end
            end
            m_dly[b][1] = m_dly[b][0];
            m_dly[b][0] = raw[b];
        end
    endtask

    task automatic chk_all();
        chk("delete", 32'(delete), 32'(m_del));
        chk("score", 32'(score), 32'(m_score));
        chk("perfect_cnt", 32'(perfect_cnt), 32'(m_perf));
        chk("good_cnt", 32'(good_cnt), 32'(m_good));
        chk("bad_cnt", 32'(bad_cnt), 32'(m_bad));
        chk("hit_flash", 32'(hit_flash), 32'(m_flash));
    endtask

    // The judge-cell note is cleared by the shifter on the edge ending the delete cycle.
    task automatic tick();
        bit dprev;
        dprev = m_del;
        @(posedge clk);
        if (rst_n) m_step(); else m_reset();
        #1;
        chk_all();
        if (delete === 1'b1) n_del++;
        if (dprev && auto_clear) begin
            note_R_judge = 1'b0;
            note_B_judge = 1'b0;
        end
    endtask

    task automatic set_btn(input int b, input bit v);
        if (b == 0) red_button = v; else blue_button = v;
    endtask

    task automatic press(input int b, input int hi, input int lo);
        set_btn(b, 1'b1);
        repeat (hi) tick();
        set_btn(b, 1'b0);
        repeat (lo) tick();
    endtask

    int del0, bad0, good0, perf0;
    int cd[2];

    initial begin
        m_reset();
        #1;
        chk("reset_score", 32'(score), 32'd0);
        chk("reset_flash", 32'(hit_flash), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Perfect red hit
        note_R_judge = 1'b1; offset = 3'd3; del0 = n_del;
        press(0, 10, 16);
        chk("t1_delete_pulses", 32'(n_del - del0), 32'd1);
        chk("t1_perfect", 32'(perfect_cnt), 32'd1);
        chk("t1_score", 32'(score), 32'(c_PP));
        chk("t1_flash_expired", 32'(hit_flash), 32'd0);

        // Good blue hit, then a second press while HOLD is kept by a stale note
        note_B_judge = 1'b1; offset = 3'd6;
        press(1, 8, 10);
        chk("t2_good", 32'(good_cnt), 32'd1);
        chk("t2_score", 32'(score), 32'(c_PP + c_GP));
        auto_clear = 1'b0; note_B_judge = 1'b1; offset = 3'd0;
        press(1, 8, 10);
        press(1, 8, 10);
        chk("t2_hold_good", 32'(good_cnt), 32'd2);
        chk("t2_hold_bad", 32'(bad_cnt), 32'd0);
        note_B_judge = 1'b0; auto_clear = 1'b1;
        repeat (2) tick();

        // Wrong-colour press, then a short glitch
        note_B_judge = 1'b1; del0 = n_del;
        press(0, 8, 10);
        chk("t3_no_delete", 32'(n_del - del0), 32'd0);
        chk("t3_bad", 32'(bad_cnt), 32'd1);
        bad0 = bad_cnt;
        press(0, 2, 12);
        chk("t3_glitch_bad", 32'(bad_cnt), 32'(bad0));

        // Both pressed together, blue matches
        offset = 3'd0; del0 = n_del; good0 = good_cnt; bad0 = bad_cnt;
        red_button = 1'b1; blue_button = 1'b1;
        repeat (8) tick();
        red_button = 1'b0; blue_button = 1'b0;
        repeat (10) tick();
        chk("t4_delete_pulses", 32'(n_del - del0), 32'd1);
        chk("t4_good", 32'(good_cnt - good0), 32'd1);
        chk("t4_bad", 32'(bad_cnt - bad0), 32'd0);

        // Drive the score into saturation
        offset = 3'd4;
        for (int i = 0; i < 5; i++) begin
            note_R_judge = 1'b1;
            press(0, 8, 8);
        end
        chk("t5_score_sat", 32'(score), 32'hFFFF);

        // finish freezes, falling finish clears
        perf0 = perfect_cnt;
        finish = 1'b1; note_R_judge = 1'b1;
        press(0, 8, 8);
        chk("t6_frozen_perf", 32'(perfect_cnt), 32'(perf0));
        chk("t6_frozen_score", 32'(score), 32'hFFFF);
        finish = 1'b0; note_R_judge = 1'b0;
        tick();
        chk("t6_clear_score", 32'(score), 32'd0);
        chk("t6_clear_perf", 32'(perfect_cnt), 32'd0);

        // Reset during HOLD with the button held
        auto_clear = 1'b0; note_R_judge = 1'b1; offset = 3'd3;
        red_button = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("t7_rst_score", 32'(score), 32'd0);
        chk("t7_rst_perf", 32'(perfect_cnt), 32'd0);
        chk("t7_rst_flash", 32'(hit_flash), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1; del0 = n_del;
        repeat (20) tick();
        chk("t7_one_event", 32'(n_del - del0), 32'd1);
        red_button = 1'b0; note_R_judge = 1'b0; auto_clear = 1'b1;
        repeat (12) tick();

        // Randomized play
        cd[0] = 0; cd[1] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 2; b++) begin
                if (cd[b] == 0) begin
                    set_btn(b, 1'($urandom_range(0, 1)));
                    cd[b] = $urandom_range(1, 14);
                end else begin
                    cd[b]--;
                end
            end
            if (!note_R_judge && !note_B_judge && $urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) note_R_judge = 1'b1; else note_B_judge = 1'b1;
            end
            offset = 3'($urandom_range(0, 6));
            if (finish) finish = ($urandom_range(0, 5) != 0);
            else finish = ($urandom_range(0, 399) == 0);
            tick();
        end
        finish = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hit_judge.md
# hit_judge

Player-input judge for the rhythm game. It debounces the red and blue play buttons and compares each press against the note currently in the judge cell, as reported by the note-chart shifter. A matching press produces the one-cycle `delete` that clears that note in the shifter. It also keeps the score, per-grade hit counters and a display flash code, and freezes them while the song `finish` flag is high.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 18'd200000: cycles a synchronized button level must stay stable before it is accepted.
- `FLASH_CYCLES`, default 24'd5000000: cycles `hit_flash` holds a grade code.
- `PERFECT_PTS`, default 16'd3: score added for a perfect hit.
- `GOOD_PTS`, default 16'd1: score added for a good hit.

Ports:
- `clk` in 1: system clock. One clock domain; all outputs are registered.
- `rst_n` in 1: reset, asynchronous, active-low.
- `red_button` in 1: raw red push button, asynchronous, active-high.
- `blue_button` in 1: raw blue push button, asynchronous, active-high.
- `note_R_judge` in 1: a red note is in the judge cell.
- `note_B_judge` in 1: a blue note is in the judge cell.
- `offset` in 3: sub-cell scroll phase, 0..6.
- `finish` in 1: song-end flag from the shifter.
- `delete` out 1: one-cycle pulse that clears the judge-cell note.
- `score` out 16: accumulated score, saturates at 16'hFFFF.
- `perfect_cnt` out 10: count of perfect hits, saturating.
- `good_cnt` out 10: count of good hits, saturating.
- `bad_cnt` out 10: count of wrong or empty presses, saturating.
- `hit_flash` out 2: 0 none, 1 perfect, 2 good, 3 bad.

## Operation
Button path, identical for each button:
- 2-flop synchronizer.
- Debounce counter: it counts while the synchronized level differs from the accepted level and resets to 0 when they match. When the count reaches `DEBOUNCE_CYCLES`-1, the accepted level toggles.
- Press event: a 1-cycle pulse on a 0->1 transition of the accepted level. A release generates no event.

State machine: PLAY, HOLD, DONE. Reset enters PLAY.
- Any state, `finish`=1: go to DONE. `delete` is not asserted.
- DONE: presses are ignored and all counters hold. When `finish`=0, go to PLAY and clear `score`, all counters and `hit_flash` on the same edge.
- PLAY, evaluated in priority order:
  - red press and `note_R_judge`=1: hit.
  - else blue press and `note_B_judge`=1: hit.
  - else any press: bad, `bad_cnt`+1, flash 3, stay in PLAY.
- Hit: `delete`=1 for one cycle, go to HOLD. Grade comes from `offset` sampled in the press-event cycle:
  - 2..4: perfect, `perfect_cnt`+1, `score`+`PERFECT_PTS`, flash 1.
  - otherwise: good, `good_cnt`+1, `score`+`GOOD_PTS`, flash 2.
- HOLD: `delete`=0 and presses are ignored. Return to PLAY once `note_R_judge` and `note_B_judge` are both 0, so one note can never be scored twice.
- Both buttons pressed in one cycle with one of them matching: one hit only, and the other press is not counted as bad.
- Both buttons pressed with neither matching: `bad_cnt`+1 once.
- Score addition uses 17 bits; the result clamps to 16'hFFFF. Counters stop at 10'h3FF.
- Flash: a new code reloads the hold counter (a new event overrides the current code). The code returns to 0 after `FLASH_CYCLES` cycles.

## Timing
- Reset values: `delete`=0, `score`=0, `perfect_cnt`=0, `good_cnt`=0, `bad_cnt`=0, `hit_flash`=0; the accepted button levels are 0; state is PLAY.
- Raw button rise to press event: 2 sync cycles + `DEBOUNCE_CYCLES` cycles + 1 cycle.
- Press event in cycle N: `delete`, the score, the counters and `hit_flash` all update on the edge ending cycle N, so `delete` is high during cycle N+1 only.
- The shifter clears the note on the edge ending N+1, so the judge input falls in N+2. HOLD is occupied for at least one cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- Reset asserted mid-debounce or mid-HOLD: everything returns to reset values immediately. A button still held at release of reset gives a press event after the debounce time.

## Test plan
(`DEBOUNCE_CYCLES`=4, `FLASH_CYCLES`=8)
- Red held 10 cycles, `note_R_judge`=1, `offset`=3 -> one `delete` pulse, `score`=3, `perfect_cnt`=1, `hit_flash`=1 for 8 cycles, then 0.
- Blue press, `note_B_judge`=1, `offset`=6; the judge input drops 1 cycle after `delete` -> `score`=1, `good_cnt`=1. A second blue press while still in HOLD does not change any count.
- Red press with only `note_B_judge`=1 -> no `delete`, `bad_cnt`=1, `hit_flash`=3. A red pulse only 2 cycles wide -> no change at all.
- Red and blue pressed in the same cycle, `note_B_judge`=1, `offset`=0 -> a single `delete`, `good_cnt`=1, `bad_cnt`=0.
- `score` preloaded to 16'hFFFE, perfect hit -> `score`=16'hFFFF. `finish`=1 during a press -> nothing changes. `finish` falling -> all counters 0 on the next edge.
- `rst_n` low during HOLD with a button held -> outputs 0 immediately. After `rst_n` rises, exactly one press event arrives after 2+4+1 cycles.
